// File: rtl/eof_error_checker_pkg.sv
// rtl/eof_error_checker_pkg.sv - shared CAN types and constants for the EOF checker
package eof_error_checker_pkg;

  // Checker FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    ERROR = 2'd2
  } eof_state_t;

  // Standard CAN end-of-frame length in bits
  localparam int CAN_EOF_LEN = 7;

  // CAN bus levels as sampled on RX
  localparam logic RECESSIVE = 1'b1;
  localparam logic DOMINANT  = 1'b0;

endpackage

// File: rtl/eof_error_checker.sv
// rtl/eof_error_checker.sv - EOF field form checker clocked by the sample-point strobe
module eof_error_checker
  import eof_error_checker_pkg::*;
#(
  parameter int EOF_LEN     = CAN_EOF_LEN,
  parameter bit IGNORE_LAST = 1'b1
) (
  input  logic reset,
  input  logic SP,
  input  logic RX,
  input  logic EOF_Flag,
  output logic EOF_Error
);

  // Counter value after the final EOF position has been checked
  localparam logic [3:0] LAST_POS = 4'(EOF_LEN);

  eof_state_t state;
  logic [3:0] bit_cnt;
  logic [3:0] bit_cnt_next;
  logic       is_last;
  logic       dominant_err;

  // Position of the bit being sampled now, and whether it is a form error
  always_comb begin
    bit_cnt_next = bit_cnt + 4'd1;
    is_last      = (bit_cnt_next == LAST_POS);
    dominant_err = (RX == DOMINANT) && !(IGNORE_LAST && is_last);
  end

  // Single FSM: arm on EOF_Flag, count recessive bits, latch the first dominant one
  always_ff @(posedge SP or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bit_cnt   <= 4'd0;
      EOF_Error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (EOF_Flag) begin
            state     <= CHECK;
            bit_cnt   <= 4'd0;
            EOF_Error <= 1'b0;
          end
        end
        CHECK: begin
          if (EOF_Flag) begin
            bit_cnt   <= 4'd0;
            EOF_Error <= 1'b0;
          end else if (dominant_err) begin
            state     <= ERROR;
            EOF_Error <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt_next;
            if (is_last) begin
              state     <= IDLE;
              EOF_Error <= 1'b0;
            end
          end
        end
        ERROR: begin
          // Sticky until a new frame arms the checker
          if (EOF_Flag) begin
            state     <= CHECK;
            bit_cnt   <= 4'd0;
            EOF_Error <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          bit_cnt   <= 4'd0;
          EOF_Error <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eof_error_checker.sv
// tb/tb_eof_error_checker.sv - randomized and directed bench for eof_error_checker
module tb_eof_error_checker;

  localparam int LEN = 7;

  logic reset = 1'b1;
  logic SP = 1'b0;
  logic RX = 1'b1;
  logic EOF_Flag = 1'b0;
  logic err_strict;
  logic err_ignore;

  int checks = 0;
  int errors = 0;

  // Reference model, index 0 = IGNORE_LAST 0, index 1 = IGNORE_LAST 1
  bit m_active [2];
  int m_seen   [2];
  bit m_err    [2];

  eof_error_checker #(.EOF_LEN(LEN), .IGNORE_LAST(1'b0)) dut_strict (
    .reset(reset), .SP(SP), .RX(RX), .EOF_Flag(EOF_Flag), .EOF_Error(err_strict)
  );

  eof_error_checker #(.EOF_LEN(LEN), .IGNORE_LAST(1'b1)) dut_ignore (
    .reset(reset), .SP(SP), .RX(RX), .EOF_Flag(EOF_Flag), .EOF_Error(err_ignore)
  );

  always #5 SP = ~SP;

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_active[k] = 0;
      m_seen[k]   = 0;
      m_err[k]    = 0;
    end
  endfunction

  // One sample point: armed frames count positions; the first dominant bit in a
  // checked position (except the last one when it is ignored) latches an error
  function automatic void model_edge(bit flag, bit rx);
    for (int k = 0; k < 2; k++) begin
      if (flag) begin
        m_active[k] = 1;
        m_seen[k]   = 0;
        m_err[k]    = 0;
      end else if (m_active[k]) begin
        m_seen[k]++;
        if (!rx && !(k == 1 && m_seen[k] == LEN)) begin
          m_err[k]    = 1;
          m_active[k] = 0;
        end else if (m_seen[k] == LEN) begin
          m_active[k] = 0;
          m_err[k]    = 0;
        end
      end
    end
  endfunction

  // Drive one SP edge, then compare both instances against the model
  task automatic step(input bit flag, input bit rx, input string name);
    EOF_Flag = flag;
    RX       = rx;
    @(posedge SP);
    #1;
    model_edge(flag, rx);
    checks++;
    if (err_strict !== m_err[0]) begin
      errors++;
      $display("FAIL %s strict: EOF_Error=%b expected %b", name, err_strict, m_err[0]);
    end
    checks++;
    if (err_ignore !== m_err[1]) begin
      errors++;
      $display("FAIL %s ignore: EOF_Error=%b expected %b", name, err_ignore, m_err[1]);
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    model_reset();
    repeat (2) @(posedge SP);
    #1;
    checks++;
    if (err_strict !== 1'b0 || err_ignore !== 1'b0) begin
      errors++;
      $display("FAIL reset: strict=%b ignore=%b expected 0", err_strict, err_ignore);
    end
    reset = 1'b1;
  endtask

  task automatic test_all_recessive();
    step(1, 1, "all_rec_arm");
    for (int i = 0; i < LEN; i++) step(0, 1, "all_rec_bit");
    // Checker is idle again: a dominant bit is no longer evaluated
    step(0, 0, "all_rec_idle");
    checks++;
    if (err_strict !== 1'b0) begin
      errors++;
      $display("FAIL all_rec_idle_const: EOF_Error=%b expected 0", err_strict);
    end
  endtask

  task automatic test_dominant_bit3();
    step(1, 1, "dom3_arm");
    step(0, 1, "dom3_b1");
    step(0, 1, "dom3_b2");
    step(0, 0, "dom3_b3");
    checks++;
    if (err_strict !== 1'b1 || err_ignore !== 1'b1) begin
      errors++;
      $display("FAIL dom3_latency: strict=%b ignore=%b expected 1", err_strict, err_ignore);
    end
    for (int i = 0; i < 5; i++) step(0, 1, "dom3_sticky");
  endtask

  task automatic test_last_bit();
    step(1, 1, "last_arm");
    for (int i = 0; i < LEN - 1; i++) step(0, 1, "last_rec");
    step(0, 0, "last_dom");
    checks++;
    if (err_strict !== 1'b1 || err_ignore !== 1'b0) begin
      errors++;
      $display("FAIL last_rule: strict=%b ignore=%b expected strict 1 ignore 0",
               err_strict, err_ignore);
    end
  endtask

  task automatic test_rearm();
    step(1, 1, "rearm_arm1");
    for (int i = 0; i < 4; i++) step(0, 1, "rearm_rec");
    step(1, 0, "rearm_arm2");
    for (int i = 0; i < LEN; i++) step(0, 1, "rearm_rec2");
    // Eighth bit after second arm is outside the window
    step(0, 0, "rearm_after");
    // Error then new arm clears on that edge
    step(1, 1, "rearm_e_arm");
    step(0, 0, "rearm_e_dom");
    step(1, 0, "rearm_e_clear");
    checks++;
    if (err_strict !== 1'b0 || err_ignore !== 1'b0) begin
      errors++;
      $display("FAIL rearm_clear: strict=%b ignore=%b expected 0", err_strict, err_ignore);
    end
    // Flag held high: nothing is counted
    for (int i = 0; i < LEN + 2; i++) step(1, 0, "rearm_hold");
    step(0, 0, "rearm_hold_dom");
  endtask

  task automatic test_async_reset();
    step(1, 1, "ares_arm");
    step(0, 0, "ares_dom");
    #2 reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (err_strict !== 1'b0 || err_ignore !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: strict=%b ignore=%b expected 0", err_strict, err_ignore);
    end
    @(negedge SP);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 0, "ares_noarm");
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      bit f;
      bit r;
      f = ($urandom_range(0, 9) == 0);
      r = ($urandom_range(0, 7) != 0);
      step(f, r, "random");
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_all_recessive();
    test_dominant_bit3();
    test_last_bit();
    test_rearm();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eof_error_checker.md
Name: eof_error_checker

Overview:
- End-of-Frame (EOF) form checker for the CAN decoder.
- When the frame decoder signals the start of the EOF field, the block checks that the following EOF bits, taken at each sample point, are recessive (RX=1).
- Any dominant bit in a checked position raises EOF_Error for the error-handling logic.
- Sits beside the frame-decoder FSM and is clocked by the bit-timing sample-point strobe.

Parameters:
- EOF_LEN, 7: number of EOF bit positions checked after arming. Legal range is 1..15.
- IGNORE_LAST, 1: if 1, a dominant bit in the last EOF position is not an error. This follows the CAN receiver rule that such a bit is an overload condition, not a form error.

Ports:
- Positional order: reset, SP, RX, EOF_Flag, EOF_Error.
- reset  input  1  asynchronous active-low reset. 0 clears all state immediately.
- SP  input  1  the single clock: bit sample point. All state updates on its rising edge.
- RX  input  1  CAN bus bit value at the sample point. 1 = recessive, 0 = dominant.
- EOF_Flag  input  1  from the frame decoder. 1 at a sample point arms the checker for the next EOF_LEN sample points.
- EOF_Error  output  1  registered error flag. 1 = dominant bit detected in a checked EOF position.

Behaviour:
- Reset (reset=0, asynchronous, any time including mid-check):
  - state=IDLE, bit counter=0, EOF_Error=0.
  - Output drops without waiting for SP.
- States:
  - IDLE: waiting for arm.
  - CHECK: counting EOF bits.
  - ERROR: dominant bit found.
- Bit counter: width is 4 bits, wide enough for EOF_LEN up to 15. It holds the number of checked bits so far.
- IDLE:
  - On an SP edge with EOF_Flag=1: go to CHECK, counter=0, EOF_Error=0.
  - RX is not checked on the arming edge.
  - Otherwise stay in IDLE; EOF_Error holds its value.
- CHECK, on each SP edge:
  - If EOF_Flag=1: re-arm. Counter=0, stay in CHECK, EOF_Error=0, RX ignored on this edge.
  - Else if RX=0 and this is not an ignored last position: go to ERROR, EOF_Error=1.
    - The flag is visible after the same SP edge that sampled the bit (1-edge latency).
  - Else: counter+1. When counter reaches EOF_LEN, go to IDLE with EOF_Error=0.
- Last-position rule: with IGNORE_LAST=1, RX=0 at position EOF_LEN is ignored, so the check completes with no error. With IGNORE_LAST=0 it is an error.
- ERROR:
  - EOF_Error stays 1 (sticky) until reset=0 or a new arm (SP edge with EOF_Flag=1).
  - A new arm goes to CHECK with EOF_Error=0.
  - RX is ignored while in ERROR.
- EOF_Flag held high on consecutive edges keeps re-arming; no bits are counted while it stays high.
- Only the first dominant bit matters; later bits are not evaluated.
- No combinational path from inputs to EOF_Error.

Decomposition:
- Shared CAN package:
  - state enum: IDLE, CHECK, ERROR.
  - constant CAN_EOF_LEN = 7.
  - constants RECESSIVE = 1, DOMINANT = 0.
- No sub-module; a single FSM with counter is sufficient.

Test Plan:
- All-recessive frame: reset=0 then 1; pulse EOF_Flag=1 for one SP, then RX=1 for 7 SPs -> EOF_Error=0 throughout and state returns to IDLE.
- Dominant at EOF bit 3: arm, RX=1,1,0 -> EOF_Error=1 after the 3rd post-arm SP edge and stays 1 for later RX=1 edges.
- Last-bit rule: arm, RX=1 for 6 SPs, then RX=0 -> EOF_Error=0 with IGNORE_LAST=1. With IGNORE_LAST=0, EOF_Error=1.
- Re-arm mid-check:
  - arm, RX=1 for 4 SPs, EOF_Flag=1 again, then 7 recessive SPs -> EOF_Error=0; the check ends 7 SPs after the second arm.
  - After an error, a new arm clears EOF_Error to 0 on that edge.
- Asynchronous reset while EOF_Error=1: drive reset=0 between SP edges -> EOF_Error=0 immediately. After reset=1 with no arm, RX=0 -> EOF_Error stays 0.
